golden_nonce_uart_tx: RTL and testbench

Downstream reporting stage for the mining top level. It watches the miner's registered `golden_nonce` output and captures each new value into a small FIFO. It then serialises each captured value to the host over an 8N1 UART line, four bytes per nonce, most significant byte first. It is the only path by which found nonces leave the device.

---
 rtl/golden_nonce_uart_tx.sv | 200 ++++++++++++++++++++
 tb/tb_golden_nonce_uart_tx.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/golden_nonce_uart_tx.sv
// Captures each new golden nonce into a FIFO and sends it MSB byte first over an 8N1 UART.
// Define NONCE_TX_SYNC_BYTE_EN to put a 0xA5 sync byte in front of every frame.
module golden_nonce_uart_tx #(
   parameter int CLKS_PER_BIT    = 4,
   parameter int FIFO_DEPTH_LOG2 = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [31:0]                golden_nonce,
   output logic                       uart_tx,
   output logic                       busy,
   output logic                       overflow,
   output logic [FIFO_DEPTH_LOG2:0]   fifo_count
);

   localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
   localparam int CNTW  = FIFO_DEPTH_LOG2 + 1;
   localparam int CW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t                     r_state;
   logic [31:0]                r_last_nonce;
   logic [31:0]                r_mem [DEPTH];
   logic [FIFO_DEPTH_LOG2-1:0] r_wr_ptr;
   logic [FIFO_DEPTH_LOG2-1:0] r_rd_ptr;
   logic [CNTW-1:0]            r_count;
   logic                       r_overflow;
   logic                       r_tx;
   logic                       r_busy;
   logic [CW-1:0]              r_clk_cnt;
   logic [2:0]                 r_bit_idx;
   logic [2:0]                 r_byte_idx;
   logic [7:0]                 r_byte;
   logic [31:0]                r_data;

   logic        w_new;
   logic        w_fifo_empty;
   logic        w_fifo_full;
   logic        w_bit_end;
   logic        w_frame_done;
   logic        w_pop;
   logic        w_push;
   logic [31:0] w_head;
   logic [7:0]  w_first_byte;
   logic [31:0] w_first_data;

`ifdef NONCE_TX_SYNC_BYTE_EN
   localparam logic [2:0] LAST_BYTE = 3'd4;
   assign w_first_byte = 8'hA5;
   assign w_first_data = w_head;
`else
   localparam logic [2:0] LAST_BYTE = 3'd3;
   assign w_first_byte = w_head[31:24];
   assign w_first_data = {w_head[23:0], 8'h00};
`endif

   assign w_new        = (golden_nonce != r_last_nonce);
   assign w_fifo_empty = (r_count == '0);
   assign w_fifo_full  = (r_count == CNTW'(DEPTH));
   assign w_bit_end    = (r_clk_cnt == CW'(CLKS_PER_BIT - 1));
   assign w_frame_done = (r_state == S_STOP) && w_bit_end && (r_byte_idx == LAST_BYTE);
   assign w_pop        = !w_fifo_empty && ((r_state == S_IDLE) || w_frame_done);
   // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
   assign w_push       = w_new && (!w_fifo_full || w_pop);
   assign w_head       = r_mem[r_rd_ptr];

   assign uart_tx    = r_tx;
   assign busy       = r_busy;
   assign overflow   = r_overflow;
   assign fifo_count = r_count;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last_nonce <= '0;
      end else if (w_new) begin
         r_last_nonce <= golden_nonce;
      end
   end

   // NOTE: the storage array has no reset; pointers and count alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= golden_nonce;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + FIFO_DEPTH_LOG2'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + FIFO_DEPTH_LOG2'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNTW'(1);
            2'b01:   r_count <= r_count - CNTW'(1);
            default: r_count <= r_count;
         endcase
         if (w_new && !w_push) begin
            r_overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_tx       <= 1'b1;
         r_busy     <= 1'b0;
         r_clk_cnt  <= '0;
         r_bit_idx  <= '0;
         r_byte_idx <= '0;
         r_byte     <= '0;
         r_data     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_clk_cnt <= '0;
               if (w_pop) begin
                  r_byte     <= w_first_byte;
                  r_data     <= w_first_data;
                  r_byte_idx <= '0;
                  r_tx       <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= S_START;
               end
            end
            S_START: begin
               if (w_bit_end) begin
                  r_clk_cnt <= '0;
                  r_tx      <= r_byte[0];
                  r_byte    <= r_byte >> 1;
                  r_bit_idx <= '0;
                  r_state   <= S_DATA;
               end else begin
                  r_clk_cnt <= r_clk_cnt + CW'(1);
               end
            end
            S_DATA: begin
               if (w_bit_end) begin
                  r_clk_cnt <= '0;
                  if (r_bit_idx == 3'd7) begin
                     r_tx    <= 1'b1;
                     r_state <= S_STOP;
                  end else begin
                     r_tx      <= r_byte[0];
                     r_byte    <= r_byte >> 1;
                     r_bit_idx <= r_bit_idx + 3'd1;
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt + CW'(1);
               end
            end
            S_STOP: begin
               if (w_bit_end) begin
                  r_clk_cnt <= '0;
                  if (r_byte_idx != LAST_BYTE) begin
                     r_byte_idx <= r_byte_idx + 3'd1;
                     r_byte     <= r_data[31:24];
                     r_data     <= r_data << 8;
                     r_tx       <= 1'b0;
                     r_state    <= S_START;
                  end else if (w_pop) begin
                     // Next frame starts straight away, no idle gap between nonces.
                     r_byte     <= w_first_byte;
                     r_data     <= w_first_data;
                     r_byte_idx <= '0;
                     r_tx       <= 1'b0;
                     r_state    <= S_START;
                  end else begin
                     r_busy  <= 1'b0;
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt + CW'(1);
               end
            end
            default: begin
               r_tx    <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_golden_nonce_uart_tx.sv
// Directed bench for golden_nonce_uart_tx: a negedge UART receiver collects bytes and busy cycles,
// and the main sequence compares them with hand-computed frames.
module tb_golden_nonce_uart_tx;

   localparam int CPB = 4;
   localparam int FL2 = 2;
`ifdef NONCE_TX_SYNC_BYTE_EN
   localparam int FRAME = 5 * 10 * CPB;
`else
   localparam int FRAME = 4 * 10 * CPB;
`endif

   logic          clk;
   logic          rst;
   logic [31:0]   golden_nonce;
   logic          uart_tx;
   logic          busy;
   logic          overflow;
   logic [FL2:0]  fifo_count;

   int total = 0;
   int bad   = 0;

   logic [7:0] rx_q [$];
   logic [7:0] exp_q [$];
   int         rx_frame_err = 0;
   int         busy_cycles  = 0;
   logic       rx_active    = 1'b0;
   int         rx_cnt       = 0;
   logic [7:0] rx_sh        = '0;

   golden_nonce_uart_tx #(
      .CLKS_PER_BIT    (CPB),
      .FIFO_DEPTH_LOG2 (FL2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .golden_nonce (golden_nonce),
      .uart_tx      (uart_tx),
      .busy         (busy),
      .overflow     (overflow),
      .fifo_count   (fifo_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Receiver: bit j of a 10-bit character occupies cycles 4j..4j+3 after the falling edge.
   always @(negedge clk) begin
      if (rst) begin
         rx_active = 1'b0;
         rx_cnt    = 0;
      end else begin
         if (busy === 1'b1) busy_cycles++;
         if (!rx_active) begin
            if (uart_tx === 1'b0) begin
               rx_active = 1'b1;
               rx_cnt    = 0;
            end
         end else begin
            rx_cnt++;
         end
         if (rx_active) begin
            if (rx_cnt == 2 && uart_tx !== 1'b0) rx_frame_err++;
            for (int j = 1; j <= 8; j++) begin
               if (rx_cnt == CPB * j + 2) rx_sh[j-1] = uart_tx;
            end
            if (rx_cnt == CPB * 9 + 2) begin
               if (uart_tx !== 1'b1) rx_frame_err++;
               rx_q.push_back(rx_sh);
            end
            if (rx_cnt == CPB * 10 - 1) rx_active = 1'b0;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_nonce(input logic [31:0] n);
`ifdef NONCE_TX_SYNC_BYTE_EN
      exp_q.push_back(8'hA5);
`endif
      exp_q.push_back(n[31:24]);
      exp_q.push_back(n[23:16]);
      exp_q.push_back(n[15:8]);
      exp_q.push_back(n[7:0]);
   endtask

   task automatic clear_capture();
      rx_q.delete();
      exp_q.delete();
      busy_cycles  = 0;
      rx_frame_err = 0;
   endtask

   task automatic check_rx(input string tag);
      check({tag, "_nbytes"}, rx_q.size(), exp_q.size());
      check({tag, "_framing"}, rx_frame_err, 0);
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         check($sformatf("%s_byte%0d", tag, i), {24'h0, rx_q[i]}, {24'h0, exp_q[i]});
      end
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n;
      n = 0;
      while (busy === 1'b1 && n < budget) begin
         tick(1);
         n++;
      end
      check({tag, "_idle_timeout"}, {31'h0, busy}, 32'h0);
   endtask

   task automatic do_reset(input string tag);
      rst          = 1'b1;
      golden_nonce = 32'h0;
      tick(2);
      check({tag, "_rst_tx"},       {31'h0, uart_tx},  32'h1);
      check({tag, "_rst_busy"},     {31'h0, busy},     32'h0);
      check({tag, "_rst_overflow"}, {31'h0, overflow}, 32'h0);
      check({tag, "_rst_count"},    {29'h0, fifo_count}, 32'h0);
      rst = 1'b0;
      clear_capture();
      tick(1);
   endtask

   logic [31:0] vals [6];

   initial begin
      rst          = 1'b1;
      golden_nonce = 32'h0;

      // 1. Single nonce: push at E1, pop at E2, one full frame.
      do_reset("t1");
      expect_nonce(32'h12345678);
      golden_nonce = 32'h12345678;
      tick(1);
      check("t1_e1_count", {29'h0, fifo_count}, 32'h1);
      check("t1_e1_tx",    {31'h0, uart_tx},    32'h1);
      check("t1_e1_busy",  {31'h0, busy},       32'h0);
      tick(1);
      check("t1_e2_tx",    {31'h0, uart_tx},    32'h0);
      check("t1_e2_busy",  {31'h0, busy},       32'h1);
      check("t1_e2_count", {29'h0, fifo_count}, 32'h0);
      wait_idle("t1", FRAME + 40);
      check("t1_busy_cycles", busy_cycles, FRAME);
      check("t1_end_count", {29'h0, fifo_count}, 32'h0);
      check("t1_end_tx",    {31'h0, uart_tx},    32'h1);
      check_rx("t1");

      // 2. Overflow: six distinct values on consecutive cycles, the sixth is dropped.
      do_reset("t2");
      vals[0] = 32'h11111111; vals[1] = 32'h22222222; vals[2] = 32'h33333333;
      vals[3] = 32'h44444444; vals[4] = 32'h55555555; vals[5] = 32'h66666666;
      for (int i = 0; i < 5; i++) expect_nonce(vals[i]);
      for (int i = 0; i < 6; i++) begin
         golden_nonce = vals[i];
         tick(1);
         if (i == 4) check("t2_ovf_before", {31'h0, overflow}, 32'h0);
      end
      check("t2_count_full", {29'h0, fifo_count}, 32'h4);
      check("t2_overflow",   {31'h0, overflow},   32'h1);
      wait_idle("t2", 6 * FRAME);
      check("t2_busy_cycles", busy_cycles, 5 * FRAME);
      check("t2_overflow_sticky", {31'h0, overflow}, 32'h1);
      check("t2_end_count", {29'h0, fifo_count}, 32'h0);
      check_rx("t2");

      // 3. Zero and unchanged input produce exactly one frame.
      do_reset("t3");
      tick(1000);
      check("t3_zero_busy",   busy_cycles, 0);
      check("t3_zero_nbytes", rx_q.size(), 0);
      check("t3_zero_tx",     {31'h0, uart_tx}, 32'h1);
      expect_nonce(32'hDEADBEEF);
      golden_nonce = 32'hDEADBEEF;
      tick(1000);
      check("t3_busy_cycles", busy_cycles, FRAME);
      check("t3_end_busy",    {31'h0, busy}, 32'h0);
      check("t3_overflow",    {31'h0, overflow}, 32'h0);
      check_rx("t3");

      // 4. Push into a full FIFO on the same edge the in-flight frame ends.
      do_reset("t4");
      vals[0] = 32'hA0000001; vals[1] = 32'hB0000002; vals[2] = 32'hC0000003;
      vals[3] = 32'hD0000004; vals[4] = 32'hE0000005; vals[5] = 32'hF0000006;
      for (int i = 0; i < 6; i++) expect_nonce(vals[i]);
      busy_cycles = 0;
      for (int i = 0; i < 5; i++) begin
         golden_nonce = vals[i];
         tick(1);
      end
      // Pop edge P was the second tick; now one cycle before P+FRAME.
      tick(FRAME - 4);
      check("t4_pre_count", {29'h0, fifo_count}, 32'h4);
      golden_nonce = vals[5];
      tick(1);
      check("t4_count_kept", {29'h0, fifo_count}, 32'h4);
      check("t4_no_overflow", {31'h0, overflow}, 32'h0);
      check("t4_busy_b2b", {31'h0, busy}, 32'h1);
      wait_idle("t4", 7 * FRAME);
      check("t4_busy_cycles", busy_cycles, 6 * FRAME);
      check("t4_end_overflow", {31'h0, overflow}, 32'h0);
      check_rx("t4");

      // 5. Asynchronous reset during DATA of byte 1, then the same nonce again.
      do_reset("t5");
      golden_nonce = 32'h0BADF00D;
      tick(2);
      tick(50);
      check("t5_mid_busy", {31'h0, busy}, 32'h1);
      rst = 1'b1;
      #1;
      check("t5_async_tx",       {31'h0, uart_tx},    32'h1);
      check("t5_async_busy",     {31'h0, busy},       32'h0);
      check("t5_async_count",    {29'h0, fifo_count}, 32'h0);
      check("t5_async_overflow", {31'h0, overflow},   32'h0);
      tick(2);
      clear_capture();
      expect_nonce(32'h0BADF00D);
      rst = 1'b0;
      tick(3);
      wait_idle("t5", FRAME + 40);
      check("t5_busy_cycles", busy_cycles, FRAME);
      check_rx("t5");

      // 6. Nonce 0x00000001; with the sync option a leading 0xA5 is expected.
      do_reset("t6");
      expect_nonce(32'h00000001);
      golden_nonce = 32'h00000001;
      tick(3);
      wait_idle("t6", FRAME + 40);
      check("t6_busy_cycles", busy_cycles, FRAME);
      check_rx("t6");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
